riscv_muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit, parametrised in DATA_WIDTH.
- Sits beside the single-cycle ALU in the execute stage.
- Decode routes ALU_S opcode with funct7 = 0000001 here and stalls on in_ready/out_valid.
- Valid/ready on both sides; one operation in flight; flush aborts the operation for branch/exception squash.

---
 rtl/riscv_definitions.sv | 33 +++
 rtl/riscv_muldiv_step.sv | 32 +++
 rtl/riscv_muldiv_unit.sv | 159 +++++++++++++++
 tb/tb_riscv_muldiv_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/riscv_definitions.sv
// Shared RV32M definitions: M-extension funct7, funct3 operation encoding,
// multiply/divide FSM states and operand-signedness helpers.
package riscv_definitions;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } mdOpType;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } mdStateType;

    // MUL only needs the low word, which is identical for signed and unsigned operands
    function automatic logic md_rs1_signed(input mdOpType op);
        return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic md_rs2_signed(input mdOpType op);
        return (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/riscv_muldiv_step.sv
// One iteration of the multiply/divide datapath on a shared 2*DATA_WIDTH accumulator:
// shift-add for multiply, restoring shift-subtract ({remainder, quotient}) for divide.
module riscv_muldiv_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      is_div,
    input  logic [DATA_WIDTH-1:0]     operand,
    input  logic [2*DATA_WIDTH-1:0]   acc_in,
    output logic [2*DATA_WIDTH-1:0]   acc_out
);

    logic [DATA_WIDTH:0] add_sum;
    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;

    always_comb begin
        add_sum = {1'b0, acc_in[2*DATA_WIDTH-1:DATA_WIDTH]}
                + (acc_in[0] ? {1'b0, operand} : {(DATA_WIDTH+1){1'b0}});
        shifted = acc_in[2*DATA_WIDTH-1:DATA_WIDTH-1];
        diff    = shifted - {1'b0, operand};
        if (is_div) begin
            // A clear borrow bit means the divisor fit: keep the difference, quotient bit 1
            if (!diff[DATA_WIDTH])
                acc_out = {diff[DATA_WIDTH-1:0], acc_in[DATA_WIDTH-2:0], 1'b1};
            else
                acc_out = {shifted[DATA_WIDTH-1:0], acc_in[DATA_WIDTH-2:0], 1'b0};
        end else begin
            acc_out = {add_sum, acc_in[DATA_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes and flush.
// Define RISCV_MULDIV_FAST_MUL_EN for single-cycle combinational multiplies.
module riscv_muldiv_unit
    import riscv_definitions::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [DATA_WIDTH-1:0] rs2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy
);

    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    mdStateType              state_reg, state_next;
    mdOpType                 op_reg, op_next;
    logic [DATA_WIDTH-1:0]   operand_reg, operand_next;
    logic [2*DATA_WIDTH-1:0] acc_reg, acc_next;
    logic                    neg_res_reg, neg_res_next;
    logic                    neg_rem_reg, neg_rem_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0]   result_reg, result_next;

    mdOpType                 op_in;
    logic                    a_neg, b_neg, div_zero, div_ovf;
    logic [DATA_WIDTH-1:0]   a_abs, b_abs;
    logic [2*DATA_WIDTH-1:0] step_out, prod_fix;
    logic [DATA_WIDTH-1:0]   quo_fix, rem_fix, final_word;

    riscv_muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .is_div  (op_reg[2]),
        .operand (operand_reg),
        .acc_in  (acc_reg),
        .acc_out (step_out)
    );

    assign op_in    = mdOpType'(op);
    assign a_neg    = md_rs1_signed(op_in) && rs1[DATA_WIDTH-1];
    assign b_neg    = md_rs2_signed(op_in) && rs2[DATA_WIDTH-1];
    assign a_abs    = a_neg ? -rs1 : rs1;
    assign b_abs    = b_neg ? -rs2 : rs2;
    assign div_zero = op[2] && (rs2 == '0);
    assign div_ovf  = ((op_in == DIV) || (op_in == REM)) && (rs1 == MOST_NEG) && (rs2 == '1);

`ifdef RISCV_MULDIV_FAST_MUL_EN
    logic [2*DATA_WIDTH-1:0] fast_prod;
    // Sign-extending to 2W and truncating the product gives the exact two's-complement result
    assign fast_prod = {{DATA_WIDTH{rs1[DATA_WIDTH-1] && md_rs1_signed(op_in)}}, rs1}
                     * {{DATA_WIDTH{rs2[DATA_WIDTH-1] && md_rs2_signed(op_in)}}, rs2};
`endif

    // Sign correction on the last iteration: the whole product is negated before word selection
    assign prod_fix   = neg_res_reg ? -step_out : step_out;
    assign quo_fix    = neg_res_reg ? -step_out[DATA_WIDTH-1:0] : step_out[DATA_WIDTH-1:0];
    assign rem_fix    = neg_rem_reg ? -step_out[2*DATA_WIDTH-1:DATA_WIDTH]
                                    : step_out[2*DATA_WIDTH-1:DATA_WIDTH];
    assign final_word = op_reg[2] ? (op_reg[1] ? rem_fix : quo_fix)
                      : ((op_reg == MUL) ? prod_fix[DATA_WIDTH-1:0]
                                         : prod_fix[2*DATA_WIDTH-1:DATA_WIDTH]);

    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        operand_next = operand_reg;
        acc_next     = acc_reg;
        neg_res_next = neg_res_reg;
        neg_rem_next = neg_rem_reg;
        cnt_next     = cnt_reg;
        result_next  = result_reg;
        case (state_reg)
            MD_IDLE: begin
                if (in_valid && !flush) begin
                    op_next      = op_in;
                    cnt_next     = '0;
                    neg_res_next = a_neg ^ b_neg;
                    neg_rem_next = a_neg;
                    operand_next = op[2] ? b_abs : a_abs;
                    acc_next     = {{DATA_WIDTH{1'b0}}, (op[2] ? a_abs : b_abs)};
                    if (div_zero) begin
                        result_next = op[1] ? rs1 : '1;
                        state_next  = MD_DONE;
                    end else if (div_ovf) begin
                        result_next = op[1] ? '0 : rs1;
                        state_next  = MD_DONE;
                    end
`ifdef RISCV_MULDIV_FAST_MUL_EN
                    else if (!op[2]) begin
                        result_next = (op_in == MUL) ? fast_prod[DATA_WIDTH-1:0]
                                                     : fast_prod[2*DATA_WIDTH-1:DATA_WIDTH];
                        state_next  = MD_DONE;
                    end
`endif
                    else begin
                        state_next = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                acc_next = step_out;
                if (cnt_reg < CNT_MAX)
                    cnt_next = cnt_reg + CNT_ONE;
                if (cnt_reg == CNT_LAST) begin
                    result_next = final_word;
                    state_next  = MD_DONE;
                end
            end
            MD_DONE: begin
                if (out_ready)
                    state_next = MD_IDLE;
            end
            default: state_next = MD_IDLE;
        endcase
        if (flush) begin
            state_next  = MD_IDLE;
            result_next = result_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= MD_IDLE;
            op_reg      <= MUL;
            operand_reg <= '0;
            acc_reg     <= '0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            cnt_reg     <= '0;
            result_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            operand_reg <= operand_next;
            acc_reg     <= acc_next;
            neg_res_reg <= neg_res_next;
            neg_rem_reg <= neg_rem_next;
            cnt_reg     <= cnt_next;
            result_reg  <= result_next;
        end
    end

    assign in_ready  = (state_reg == MD_IDLE) && !flush;
    assign out_valid = (state_reg == MD_DONE);
    assign busy      = (state_reg != MD_IDLE);
    assign result    = result_reg;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed self-checking bench for riscv_muldiv_unit (DATA_WIDTH=32); honours RISCV_MULDIV_FAST_MUL_EN.
module tb_riscv_muldiv_unit;

`ifdef RISCV_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int total = 0;
    int bad = 0;

    riscv_muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one operation, measure cycles from the accept edge to out_valid, then consume it.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expected, input int exp_lat);
        int lat;
        logic ready_low;
        op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
        check({tag, " in_ready_before"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        ready_low = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_low = 1'b0;
            tick();
            lat++;
        end
        if (in_ready) ready_low = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, result, expected);
        check({tag, " in_ready_low"}, 32'(ready_low), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " out_valid_clear"}, 32'(out_valid), 32'd0);
        $display("op=%0d rs1=0x%08h rs2=0x%08h result=0x%08h latency=%0d", o, a, b, expected, lat);
    endtask

    initial begin
        logic [31:0] held;
        logic        seen_valid;

        // Reset state
        tick(); tick();
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", result, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Multiplies
        run_op("MUL", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("MULH", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);

        // Divides
        run_op("DIV", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
        run_op("REM", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
        run_op("DIVU", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT);
        run_op("REMU", 3'b111, 32'd100, 32'd7, 32'd2, DIV_LAT);

        // Special cases resolved at accept
        run_op("DIV_BY_ZERO", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("REMU_BY_ZERO", 3'b111, 32'd5, 32'd0, 32'd5, 1);
        run_op("DIV_OVF", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("REM_OVF", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // Back-pressure: result held 5 cycles, new requests ignored
        op = 3'b101; rs1 = 32'd100; rs2 = 32'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 40 && !out_valid; i++) tick();
        op = 3'b000; rs1 = 32'd3; rs2 = 32'd3; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp result", result, 32'd14);
            check("bp in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("bp idle after consume", 32'(busy), 32'd0);
        $display("backpressure: held result 0x%08h for 5 cycles", 32'd14);

        // Flush in cycle T+10 of a divide
        held = result;
        op = 3'b101; rs1 = 32'd1000; rs2 = 32'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        check("flush in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        check("flush busy", 32'(busy), 32'd0);
        check("flush result", result, held);
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen_valid = 1'b1;
            tick();
        end
        check("flush no out_valid", 32'(seen_valid), 32'd0);
        $display("flush: aborted DIVU at T+10, result stays 0x%08h", held);

        // Reset in the middle of a calculation
        run_op("DIVU_PRE_RST", 3'b101, 32'd45, 32'd4, 32'd11, DIV_LAT);
        op = 3'b100; rs1 = 32'd77; rs2 = 32'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        check("midcalc rst out_valid", 32'(out_valid), 32'd0);
        check("midcalc rst result", result, 32'd0);
        check("midcalc rst busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();
        $display("reset mid-CALC: outputs cleared");

        run_op("MUL_POST_RST", 3'b000, 32'd12345, 32'd678, 32'd8369910, MUL_LAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
